// File: rtl/tiny_nn_result_collect_if.sv
// Byte-in / word-out stream bundle for tiny_nn_result_collect.
// slave: the collector; master: datapath/host side driving bytes and ready.
interface tiny_nn_result_collect_if #(
    parameter int Depth = 4
);
    localparam int PtrWidth = $clog2(Depth);

    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_hi_i;
    logic              clear_i;
    logic [15:0]       res_o;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [PtrWidth:0] count_o;
    logic              err_seq_o;
    logic              err_ovf_o;
`ifdef TINY_NN_RESULT_DROP_CNT_EN
    logic [7:0]        drop_cnt_o;
`endif

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        input  byte_hi_i,
        input  clear_i,
        input  res_ready_i,
        output res_o,
        output res_valid_o,
        output count_o,
        output err_seq_o,
`ifdef TINY_NN_RESULT_DROP_CNT_EN
        output drop_cnt_o,
`endif
        output err_ovf_o
    );

    modport master (
        output byte_i,
        output byte_valid_i,
        output byte_hi_i,
        output clear_i,
        output res_ready_i,
        input  res_o,
        input  res_valid_o,
        input  count_o,
        input  err_seq_o,
`ifdef TINY_NN_RESULT_DROP_CNT_EN
        input  drop_cnt_o,
`endif
        input  err_ovf_o
    );
endinterface

// File: rtl/tiny_nn_result_collect.sv
// Reassembles lo/hi result bytes into 16-bit words, buffers them in a
// Depth-entry FIFO and streams them out with sticky error flags.
// Ports: clk_i, rst_ni (async, active-low), bus (slave modport):
//   byte_i/byte_valid_i/byte_hi_i in, clear_i flush, res_o/res_valid_o/
//   res_ready_i stream out, count_o occupancy, err_seq_o, err_ovf_o.
// Option TINY_NN_RESULT_DROP_CNT_EN adds bus.drop_cnt_o, a saturating
// count of words dropped on overflow.
module tiny_nn_result_collect #(
    parameter int Depth = 4
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    tiny_nn_result_collect_if.slave   bus
);
    localparam int PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth:0] CntFull = (PtrWidth + 1)'(Depth);
    localparam logic [PtrWidth-1:0] PtrOne = PtrWidth'(1);
    localparam logic [PtrWidth:0] CntOne = (PtrWidth + 1)'(1);

    localparam logic [0:0] StWaitLo = 1'b0;
    localparam logic [0:0] StWaitHi = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [7:0]          low_q, low_d;
    logic [15:0]         mem_q [Depth];
    logic [15:0]         mem_d [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrWidth:0]   count_q, count_d;
    logic                err_seq_q, err_seq_d;
    logic                err_ovf_q, err_ovf_d;
`ifdef TINY_NN_RESULT_DROP_CNT_EN
    logic [7:0]          drop_cnt_q, drop_cnt_d;
`endif

    logic        pop;
    logic        push_req;
    logic        push_ok;
    logic        drop;
    logic        full;
    logic [15:0] word;

    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_seq_d = err_seq_q;
        err_ovf_d = err_ovf_q;
`ifdef TINY_NN_RESULT_DROP_CNT_EN
        drop_cnt_d = drop_cnt_q;
`endif
        pop      = (count_q != '0) && bus.res_ready_i;
        full     = (count_q == CntFull);
        push_req = 1'b0;
        word     = {bus.byte_i, low_q};

        if (bus.clear_i) begin
            // Flush wins over any byte or pop in the same cycle.
            pop       = 1'b0;
            state_d   = StWaitLo;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_seq_d = 1'b0;
            err_ovf_d = 1'b0;
`ifdef TINY_NN_RESULT_DROP_CNT_EN
            drop_cnt_d = '0;
`endif
        end else if (bus.byte_valid_i) begin
            unique case (state_q)
                StWaitLo: begin
                    if (bus.byte_hi_i) begin
                        err_seq_d = 1'b1;
                    end else begin
                        low_d   = bus.byte_i;
                        state_d = StWaitHi;
                    end
                end
                StWaitHi: begin
                    if (bus.byte_hi_i) begin
                        push_req = 1'b1;
                        state_d  = StWaitLo;
                    end else begin
                        // A repeated low byte replaces the pending one.
                        low_d     = bus.byte_i;
                        err_seq_d = 1'b1;
                    end
                end
                default: state_d = StWaitLo;
            endcase
        end

        // A pop in the same cycle frees the slot a full-FIFO push needs.
        push_ok = push_req && (!full || pop);
        drop    = push_req && full && !pop;

        if (push_ok) begin
            mem_d[wr_ptr_q] = word;
            wr_ptr_d        = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (!bus.clear_i) begin
            unique case ({push_ok, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
        if (drop) begin
            err_ovf_d = 1'b1;
`ifdef TINY_NN_RESULT_DROP_CNT_EN
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StWaitLo;
            low_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_seq_q <= 1'b0;
            err_ovf_q <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
`ifdef TINY_NN_RESULT_DROP_CNT_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            low_q     <= low_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_seq_q <= err_seq_d;
            err_ovf_q <= err_ovf_d;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef TINY_NN_RESULT_DROP_CNT_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    assign bus.res_o       = mem_q[rd_ptr_q];
    assign bus.res_valid_o = (count_q != '0);
    assign bus.count_o     = count_q;
    assign bus.err_seq_o   = err_seq_q;
    assign bus.err_ovf_o   = err_ovf_q;
`ifdef TINY_NN_RESULT_DROP_CNT_EN
    assign bus.drop_cnt_o  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_tiny_nn_result_collect.sv
// Self-checking bench for tiny_nn_result_collect against a queue model.
// Directed steps plus randomized streams in one initial block.
module tb_tiny_nn_result_collect;
    localparam int Depth = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    tiny_nn_result_collect_if #(.Depth(Depth)) bus ();

    tiny_nn_result_collect #(.Depth(Depth)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: word queue, pending low byte, flags.
    logic [15:0] mq[$];
    bit          m_have_lo;
    logic [7:0]  m_lo;
    bit          m_eseq;
    bit          m_eovf;
    int          m_drop;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_have_lo = 0;
        m_lo = 8'h00;
        m_eseq = 0;
        m_eovf = 0;
        m_drop = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cnt"}, 16'(bus.count_o), 16'(mq.size()));
        chk({tag, ".vld"}, 16'(bus.res_valid_o), 16'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".res"}, bus.res_o, mq[0]);
        chk({tag, ".eseq"}, 16'(bus.err_seq_o), 16'(m_eseq));
        chk({tag, ".eovf"}, 16'(bus.err_ovf_o), 16'(m_eovf));
`ifdef TINY_NN_RESULT_DROP_CNT_EN
        chk({tag, ".drop"}, 16'(bus.drop_cnt_o), 16'(m_drop));
`endif
    endtask

    // Apply the block's rules to the model for the inputs now driven,
    // then advance one clock and compare.
    task automatic tick(input string tag);
        int  sz;
        bit  pop;
        sz  = mq.size();
        pop = (sz > 0) && bus.res_ready_i;
        if (bus.clear_i) begin
            mq.delete();
            m_have_lo = 0;
            m_eseq = 0;
            m_eovf = 0;
            m_drop = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (bus.byte_valid_i) begin
                if (!m_have_lo) begin
                    if (bus.byte_hi_i) m_eseq = 1;
                    else begin
                        m_lo = bus.byte_i;
                        m_have_lo = 1;
                    end
                end else if (bus.byte_hi_i) begin
                    m_have_lo = 0;
                    if (sz == Depth && !pop) begin
                        m_eovf = 1;
                        if (m_drop < 255) m_drop++;
                    end else begin
                        mq.push_back({bus.byte_i, m_lo});
                    end
                end else begin
                    m_lo = bus.byte_i;
                    m_eseq = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
        bus.byte_hi_i = 1'b0;
        bus.clear_i = 1'b0;
        check_all(tag);
    endtask

    task automatic send(input logic [7:0] b, input bit hi, input string tag);
        bus.byte_i = b;
        bus.byte_valid_i = 1'b1;
        bus.byte_hi_i = hi;
        tick(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic pop1(input logic [15:0] exp, input string tag);
        chk({tag, ".head"}, bus.res_o, exp);
        bus.res_ready_i = 1'b1;
        tick(tag);
        bus.res_ready_i = 1'b0;
    endtask

    initial begin
        logic [15:0] sent[$];
        logic [15:0] got[$];
        logic [15:0] w;

        bus.byte_i = 8'hFF;
        bus.byte_valid_i = 1'b0;
        bus.byte_hi_i = 1'b0;
        bus.clear_i = 1'b0;
        bus.res_ready_i = 1'b0;
        model_reset();
        #12;
        chk("rst.res", bus.res_o, 16'h0000);
        check_all("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic pair
        send(8'h34, 0, "basic.lo");
        chk("basic.novld", 16'(bus.res_valid_o), 16'd0);
        send(8'h12, 1, "basic.hi");
        chk("basic.word", bus.res_o, 16'h1234);
        chk("basic.cnt1", 16'(bus.count_o), 16'd1);
        pop1(16'h1234, "basic.pop");
        chk("basic.cnt0", 16'(bus.count_o), 16'd0);

        // Gapped then back-to-back
        send(8'hCD, 0, "gap.lo");
        idle(3, "gap.idle");
        send(8'hAB, 1, "gap.hi");
        send(8'h01, 0, "b2b.lo0");
        send(8'h00, 1, "b2b.hi0");
        send(8'hFF, 0, "b2b.lo1");
        send(8'h7F, 1, "b2b.hi1");
        pop1(16'hABCD, "gap.pop0");
        pop1(16'h0001, "gap.pop1");
        pop1(16'h7FFF, "gap.pop2");
        chk("gap.eseq", 16'(bus.err_seq_o), 16'd0);

        // Sequence errors
        send(8'h55, 1, "seq.hifirst");
        chk("seq.flag", 16'(bus.err_seq_o), 16'd1);
        chk("seq.empty", 16'(bus.count_o), 16'd0);
        send(8'h11, 0, "seq.lo1");
        send(8'h22, 0, "seq.lo2");
        send(8'h33, 1, "seq.hi");
        chk("seq.cnt", 16'(bus.count_o), 16'd1);
        pop1(16'h3322, "seq.pop");

        bus.clear_i = 1'b1;
        tick("clr0");

        // Overflow: five words with ready low
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h10 + i), 0, "ovf.lo");
            send(8'(8'hA0 + i), 1, "ovf.hi");
        end
        chk("ovf.cnt", 16'(bus.count_o), 16'd4);
        chk("ovf.flag", 16'(bus.err_ovf_o), 16'd1);
        chk("ovf.head", bus.res_o, 16'hA010);
        send(8'h77, 0, "ovf.lo5");
        bus.res_ready_i = 1'b1;
        send(8'h66, 1, "ovf.pushpop");
        bus.res_ready_i = 1'b0;
        chk("ovf.cntfull", 16'(bus.count_o), 16'd4);
        chk("ovf.head2", bus.res_o, 16'hA111);
        for (int i = 0; i < 4; i++) begin
            w = mq[0];
            pop1(w, "ovf.drain");
        end
        chk("ovf.last", 16'(bus.count_o), 16'd0);

        bus.clear_i = 1'b1;
        tick("clr1");
        chk("clr1.eovf", 16'(bus.err_ovf_o), 16'd0);

        // Wrap-around with random ready stalls
        for (int i = 0; i < 10; i++) begin
            w = 16'($urandom);
            sent.push_back(w);
            for (int k = 0; k < 2; k++) begin
                if (bus.res_valid_o && bus.res_ready_i)
                    got.push_back(bus.res_o);
                bus.res_ready_i = 1'($urandom_range(0, 1));
                if (mq.size() == Depth && k == 1) bus.res_ready_i = 1'b1;
                if (bus.res_valid_o && bus.res_ready_i)
                    got.push_back(bus.res_o);
                send(k ? w[15:8] : w[7:0], k[0], "wrap");
                bus.res_ready_i = 1'b0;
                chk("wrap.le4", 16'(bus.count_o <= 3'd4), 16'd1);
            end
        end
        bus.res_ready_i = 1'b1;
        for (int i = 0; i < 12 && bus.res_valid_o; i++) begin
            got.push_back(bus.res_o);
            tick("wrap.drain");
        end
        bus.res_ready_i = 1'b0;
        chk("wrap.n", 16'(got.size()), 16'(sent.size()));
        for (int i = 0; i < sent.size() && i < got.size(); i++)
            chk("wrap.ord", got[i], sent[i]);
        chk("wrap.eovf", 16'(bus.err_ovf_o), 16'd0);

        // Clear mid-word
        send(8'h99, 0, "cm.lo");
        bus.clear_i = 1'b1;
        tick("cm.clr");
        send(8'h88, 1, "cm.hi");
        chk("cm.eseq", 16'(bus.err_seq_o), 16'd1);
        chk("cm.empty", 16'(bus.count_o), 16'd0);

        // Clear with a same-cycle byte: byte ignored
        send(8'h42, 0, "cb.lo");
        bus.byte_i = 8'h24;
        bus.byte_valid_i = 1'b1;
        bus.byte_hi_i = 1'b1;
        bus.clear_i = 1'b1;
        tick("cb.clr");
        chk("cb.empty", 16'(bus.count_o), 16'd0);

        // Async reset with two words queued and a pending low byte
        send(8'h01, 0, "ar.lo0");
        send(8'hC0, 1, "ar.hi0");
        send(8'h02, 0, "ar.lo1");
        send(8'hC0, 1, "ar.hi1");
        send(8'h5A, 0, "ar.pend");
        chk("ar.cnt2", 16'(bus.count_o), 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar.vld", 16'(bus.res_valid_o), 16'd0);
        chk("ar.cnt", 16'(bus.count_o), 16'd0);
        chk("ar.res", bus.res_o, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'hEE, 1, "ar.hilost");
        chk("ar.eseq", 16'(bus.err_seq_o), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tiny_nn_result_collect.md
Name: tiny_nn_result_collect

Overview:
- Downstream of the tiny_nn top-level datapath.
- During convolve execution the datapath emits each fp16 accumulate result as two bytes on an 8-bit bus: low byte on phase 0, high byte on phase 1. It drives 0xFF when not executing.
- This block re-assembles byte pairs into 16-bit results and buffers them in a small FIFO.
- The buffered results are presented on a valid/ready stream for a host-side reader, along with sticky error flags.

Parameters:
- Depth, 4, FIFO entries; power of two, minimum 2.
- PtrWidth, $clog2(Depth), FIFO pointer width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- byte_i  input  8  result byte from datapath.
- byte_valid_i  input  1  byte_i carries a result byte this cycle (datapath exec state).
- byte_hi_i  input  1  0 = low byte (phase 0), 1 = high byte (phase 1).
- clear_i  input  1  synchronous flush of FIFO, partial word and flags.
- res_o  output  16  result at FIFO head.
- res_valid_o  output  1  res_o is valid.
- res_ready_i  input  1  consumer accepts res_o.
- count_o  output  PtrWidth+1  FIFO occupancy, 0..Depth.
- err_seq_o  output  1  sticky protocol-sequence error.
- err_ovf_o  output  1  sticky FIFO overflow.

Behaviour:
- Reset: FIFO empty, count_o=0, res_valid_o=0, res_o=0, have_low=0, err_seq_o=0, err_ovf_o=0.
- Byte assembly: a 2-state FSM.
  - WAIT_LO:
    - byte_valid_i & !byte_hi_i: latch byte_i into low_q, go to WAIT_HI.
    - byte_valid_i & byte_hi_i: discard the byte, set err_seq_o, stay in WAIT_LO.
  - WAIT_HI:
    - byte_valid_i & byte_hi_i: form word {byte_i, low_q}, push it, go to WAIT_LO.
    - byte_valid_i & !byte_hi_i: overwrite low_q with byte_i, set err_seq_o, stay in WAIT_HI.
  - byte_valid_i=0: FSM holds its state; gaps of any length between bytes are allowed.
- Push latency: a word pushed at edge N is visible on res_o / res_valid_o from cycle N+1. There is no combinational path from byte_i to res_o.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr and a separate count register.
  - Pointers wrap modulo Depth.
  - res_o = mem[rd_ptr]; res_valid_o = (count != 0).
  - Pop when res_valid_o & res_ready_i.
  - res_ready_i while empty: no effect.
- Full boundary:
  - Push while count==Depth with no pop in the same cycle: word dropped, err_ovf_o set, FIFO unchanged.
  - Push and pop in the same cycle when full: both proceed, count stays at Depth, no overflow.
  - Push and pop in the same cycle at any other occupancy: count unchanged, pointers both advance.
- Empty boundary: there is no bypass. A push to an empty FIFO appears one cycle later.
- clear_i:
  - Has priority over all same-cycle events.
  - Empties the FIFO, returns the FSM to WAIT_LO, clears both error flags and the optional drop counter.
  - Any byte in the same cycle is ignored.
- Async reset mid-transfer: all state returns to reset values immediately; a pending low byte is lost.
- Error flags: sticky until clear_i or reset.

Optional Feature:
- Macro: TINY_NN_RESULT_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt_o [7:0].
  - Counts words dropped on overflow.
  - Saturates at 0xFF and does not wrap.
  - Cleared by reset or clear_i.
- When undefined:
  - Port and counter are absent.
  - err_ovf_o alone signals overflow; behaviour is otherwise identical.

Test Plan:
- Basic pair: bytes 0x34 (lo) then 0x12 (hi) in consecutive cycles → next cycle res_valid_o=1, res_o=0x1234, count_o=1; pop with res_ready_i=1 → count_o=0.
- Gapped and back-to-back:
  - Pairs (0xCD,0xAB) with 3 idle cycles between the bytes, then (0x01,0x00) then (0xFF,0x7F) → FIFO yields 0xABCD, 0x0001, 0x7FFF in order.
  - err flags remain 0.
- Sequence errors:
  - hi byte 0x55 first → err_seq_o=1, nothing pushed.
  - Then lo 0x11, lo 0x22, hi 0x33 → single word 0x3322.
- Overflow (Depth=4):
  - Push 5 words with res_ready_i=0 → count_o=4, err_ovf_o=1, 5th word absent.
  - With macro defined, drop_cnt_o=1.
  - Then push while popping at full → count_o stays 4, drop count unchanged.
- Wrap-around: stream 10 words with random ready stalls → output order and values match input; count_o never exceeds 4.
- Clear/reset mid-op:
  - Lo byte 0x99 then clear_i, then hi 0x88 → err_seq_o=1, FIFO empty.
  - Assert rst_ni low with 2 entries queued → res_valid_o=0 and count_o=0 immediately, before the next clock edge.
